// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Brief    : Shared AES constants, controller encodings and round helpers
//            (GF(2^8) multiply-by-2/3, MixColumns, ShiftRows, AddRoundKey).
// Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

  // Key length selector values
  localparam logic AES_128_BIT_KEY = 1'b0;
  localparam logic AES_256_BIT_KEY = 1'b1;

  // Number of rounds per key length
  localparam logic [3:0] AES128_ROUNDS = 4'd10;
  localparam logic [3:0] AES256_ROUNDS = 4'd14;

  // Controller state encodings
  localparam logic [1:0] CTRL_IDLE = 2'd0;
  localparam logic [1:0] CTRL_INIT = 2'd1;
  localparam logic [1:0] CTRL_SBOX = 2'd2;
  localparam logic [1:0] CTRL_MAIN = 2'd3;

  // State register update selectors
  localparam logic [2:0] UPD_NO    = 3'd0;
  localparam logic [2:0] UPD_INIT  = 3'd1;
  localparam logic [2:0] UPD_SBOX  = 3'd2;
  localparam logic [2:0] UPD_MAIN  = 3'd3;
  localparam logic [2:0] UPD_FINAL = 3'd4;

  // Multiply by 2 in GF(2^8), reduction polynomial 0x1b
  function automatic logic [7:0] gm2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by 3 in GF(2^8)
  function automatic logic [7:0] gm3(input logic [7:0] b);
    return gm2(b) ^ b;
  endfunction

  // MixColumns on one column; byte 0 (row 0) is the most significant byte
  function automatic logic [31:0] mixw(input logic [31:0] w);
    logic [7:0] b0, b1, b2, b3;
    logic [7:0] m0, m1, m2, m3;
    b0 = w[31:24];
    b1 = w[23:16];
    b2 = w[15:8];
    b3 = w[7:0];
    m0 = gm2(b0) ^ gm3(b1) ^ b2      ^ b3;
    m1 = b0      ^ gm2(b1) ^ gm3(b2) ^ b3;
    m2 = b0      ^ b1      ^ gm2(b2) ^ gm3(b3);
    m3 = gm3(b0) ^ b1      ^ b2      ^ gm2(b3);
    return {m0, m1, m2, m3};
  endfunction

  // MixColumns over the full state {w0,w1,w2,w3}
  function automatic logic [127:0] mixcolumns(input logic [127:0] s);
    return {mixw(s[127:96]), mixw(s[95:64]), mixw(s[63:32]), mixw(s[31:0])};
  endfunction

  // ShiftRows: output column c takes row r from column (c+r) mod 4
  function automatic logic [127:0] shiftrows(input logic [127:0] s);
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] ws0, ws1, ws2, ws3;
    w0  = s[127:96];
    w1  = s[95:64];
    w2  = s[63:32];
    w3  = s[31:0];
    ws0 = {w0[31:24], w1[23:16], w2[15:8], w3[7:0]};
    ws1 = {w1[31:24], w2[23:16], w3[15:8], w0[7:0]};
    ws2 = {w2[31:24], w3[23:16], w0[15:8], w1[7:0]};
    ws3 = {w3[31:24], w0[23:16], w1[15:8], w2[7:0]};
    return {ws0, ws1, ws2, ws3};
  endfunction

  // AddRoundKey
  function automatic logic [127:0] addroundkey(input logic [127:0] s,
                                                input logic [127:0] k);
    return s ^ k;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module   : aes_sbox
// Brief    : Combinational forward AES S-box applied to all four bytes of a
//            32-bit word.
// Revision : 1.0 - initial release
// ============================================================================
module aes_sbox
  import aes_pkg::*;
(
  input  logic [31:0] sboxw_i,
  output logic [31:0] new_sboxw_o
);

  // Forward S-box table, entry 0 in the most significant byte
  localparam logic [0:255][7:0] C_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign new_sboxw_o[8*i +: 8] = C_SBOX[sboxw_i[8*i +: 8]];
  end

endmodule
`default_nettype wire

// File: rtl/aes_encipher_block.sv
`default_nettype none
// ============================================================================
// Module   : aes_encipher_block
// Brief    : Iterative AES encipher datapath for 128/256-bit keys. One S-box
//            word per cycle, five cycles per round, round keys fetched
//            combinationally by the exported round index.
// Revision : 1.0 - initial release
// ============================================================================
module aes_encipher_block
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         next,
  input  logic         keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
);

  logic [1:0]   ctrl_q, ctrl_d;
  logic [3:0]   round_ctr_q, round_ctr_d;
  logic [1:0]   sword_ctr_q, sword_ctr_d;
  logic         keylen_q, keylen_d;
  logic         ready_q, ready_d;
  logic [127:0] block_q, block_d;

  logic [2:0]   w_upd;
  logic [3:0]   w_num_rounds;
  logic         w_final_round;
  logic [31:0]  w_sboxw;
  logic [31:0]  w_new_sboxw;

  assign w_num_rounds  = (keylen_q == AES_256_BIT_KEY) ? AES256_ROUNDS : AES128_ROUNDS;
  assign w_final_round = (round_ctr_q == w_num_rounds);

  aes_sbox u_sbox (
    .sboxw_i     (w_sboxw),
    .new_sboxw_o (w_new_sboxw)
  );

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q      <= CTRL_IDLE;
      round_ctr_q <= 4'd0;
      sword_ctr_q <= 2'd0;
      keylen_q    <= AES_128_BIT_KEY;
      ready_q     <= 1'b1;
      block_q     <= 128'd0;
    end else begin
      ctrl_q      <= ctrl_d;
      round_ctr_q <= round_ctr_d;
      sword_ctr_q <= sword_ctr_d;
      keylen_q    <= keylen_d;
      ready_q     <= ready_d;
      block_q     <= block_d;
    end
  end

  // Next-state logic of the round controller
  always_comb begin
    ctrl_d = ctrl_q;
    case (ctrl_q)
      CTRL_IDLE: if (next) ctrl_d = CTRL_INIT;
      CTRL_INIT: ctrl_d = CTRL_SBOX;
      CTRL_SBOX: if (sword_ctr_q == 2'd3) ctrl_d = CTRL_MAIN;
      CTRL_MAIN: ctrl_d = w_final_round ? CTRL_IDLE : CTRL_SBOX;
      default:   ctrl_d = CTRL_IDLE;
    endcase
  end

  // Controller outputs: counters, ready, keylen capture and update selector
  always_comb begin
    w_upd       = UPD_NO;
    round_ctr_d = round_ctr_q;
    sword_ctr_d = sword_ctr_q;
    keylen_d    = keylen_q;
    ready_d     = ready_q;
    case (ctrl_q)
      CTRL_IDLE: begin
        if (next) begin
          round_ctr_d = 4'd0;
          keylen_d    = keylen;
          ready_d     = 1'b0;
        end
      end
      CTRL_INIT: begin
        w_upd       = UPD_INIT;
        round_ctr_d = 4'd1;
        sword_ctr_d = 2'd0;
      end
      CTRL_SBOX: begin
        w_upd       = UPD_SBOX;
        sword_ctr_d = sword_ctr_q + 2'd1;
      end
      CTRL_MAIN: begin
        if (w_final_round) begin
          // round stays at Nr so the key memory keeps the last index
          w_upd   = UPD_FINAL;
          ready_d = 1'b1;
        end else begin
          w_upd       = UPD_MAIN;
          round_ctr_d = round_ctr_q + 4'd1;
        end
      end
      default: ;
    endcase
  end

  // Select the state word currently passing through the S-box
  always_comb begin
    case (sword_ctr_q)
      2'd0:    w_sboxw = block_q[127:96];
      2'd1:    w_sboxw = block_q[95:64];
      2'd2:    w_sboxw = block_q[63:32];
      default: w_sboxw = block_q[31:0];
    endcase
  end

  // State register update according to the controller's selector
  always_comb begin
    block_d = block_q;
    case (w_upd)
      UPD_INIT: block_d = addroundkey(block, round_key);
      UPD_SBOX: begin
        case (sword_ctr_q)
          2'd0:    block_d[127:96] = w_new_sboxw;
          2'd1:    block_d[95:64]  = w_new_sboxw;
          2'd2:    block_d[63:32]  = w_new_sboxw;
          default: block_d[31:0]   = w_new_sboxw;
        endcase
      end
      UPD_MAIN:  block_d = addroundkey(mixcolumns(shiftrows(block_q)), round_key);
      UPD_FINAL: block_d = addroundkey(shiftrows(block_q), round_key);
      default: ;
    endcase
  end

  assign round     = round_ctr_q;
  assign new_block = block_q;
  assign ready     = ready_q;

endmodule
`default_nettype wire
